// File: rtl/parking_defs.sv
// parking_defs: lane state encoding and width helpers shared by the parking lane controller
package parking_defs;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_PIN  = 3'd1,
        S_WRONG_PIN = 3'd2,
        S_OPEN      = 3'd3,
        S_CLOSING   = 3'd4,
        S_BLOCKED   = 3'd5
    } lane_state_t;

    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/parking_lane_fsm.sv
// parking_lane_fsm: one entry lane (PIN check, retries, timed close, tailgate, unlock); LOCKOUT_TIMER_EN adds BLOCKED auto-release
module parking_lane_fsm
    import parking_defs::*;
#(
    parameter int               PIN_W          = 16,
    parameter logic [PIN_W-1:0] CORRECT_PIN    = 16'h2468,
    parameter int               MAX_ATTEMPTS   = 3,
    parameter int               CLOSE_CYCLES   = 4,
    parameter int               LOCKOUT_CYCLES = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_arrival,
    input  logic             i_left,
    input  logic [PIN_W-1:0] i_code,
    input  logic             i_code_ack,
    input  logic             i_admin_unlock,
    input  logic             i_lot_full,
    output logic             o_open,
    output logic             o_close,
    output logic             o_wrong,
    output logic             o_blocked,
    output logic             o_inc
);

    localparam int AW = cnt_w(MAX_ATTEMPTS);
    localparam int CW = cnt_w(CLOSE_CYCLES);

    lane_state_t   r_state, w_next;
    logic [AW-1:0] r_attempts;
    logic [AW-1:0] w_att_inc;
    logic [CW-1:0] r_close;
    logic          w_wrong;
    logic          w_close_done;
    logic          w_lock_done;

    assign w_att_inc    = r_attempts + 1'b1;
    assign w_wrong      = i_code_ack && (i_code != CORRECT_PIN);
    assign w_close_done = r_close == CW'(CLOSE_CYCLES - 1);

`ifdef LOCKOUT_TIMER_EN
    localparam int LW = cnt_w(LOCKOUT_CYCLES);
    logic [LW-1:0] r_lock;
    assign w_lock_done = r_lock == LW'(LOCKOUT_CYCLES - 1);
    // counts cycles spent in BLOCKED, restarting on every entry
    always_ff @(posedge clk) begin
        if (rst) r_lock <= '0;
        else     r_lock <= (r_state == S_BLOCKED) ? r_lock + 1'b1 : '0;
    end
`else
    assign w_lock_done = 1'b0;
`endif

    // next-state selection; code_ack wins over vehicle_left while waiting for a PIN
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:      if (i_arrival && !i_lot_full) w_next = S_WAIT_PIN;
            S_WAIT_PIN:  if (i_code_ack) w_next = !w_wrong ? S_OPEN :
                                                  (w_att_inc == AW'(MAX_ATTEMPTS)) ? S_BLOCKED : S_WRONG_PIN;
                         else if (i_left) w_next = S_IDLE;
            S_WRONG_PIN: if (!i_code_ack) w_next = S_WAIT_PIN;
            S_OPEN:      if (i_left) w_next = i_arrival ? S_BLOCKED : S_CLOSING;
            S_CLOSING:   if (w_close_done) w_next = S_IDLE;
            S_BLOCKED:   if (i_admin_unlock || w_lock_done) w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

    // state register plus retry and close counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_attempts <= '0;
            r_close    <= '0;
        end else begin
            r_state <= w_next;
            r_close <= (r_state == S_CLOSING) ? r_close + 1'b1 : '0;
            if (r_state == S_OPEN || (r_state == S_BLOCKED && w_next == S_IDLE))
                r_attempts <= '0;
            else if (r_state == S_WAIT_PIN && w_wrong)
                r_attempts <= w_att_inc;
        end
    end

    assign o_open    = r_state == S_OPEN;
    assign o_close   = r_state == S_CLOSING;
    assign o_wrong   = r_state == S_WRONG_PIN;
    assign o_blocked = r_state == S_BLOCKED;
    assign o_inc     = (r_state == S_OPEN) && i_left && !i_arrival;

endmodule

// File: rtl/parking_lane_controller.sv
// parking_lane_controller: N_LANES gate FSMs sharing a saturating occupancy counter; LOCKOUT_TIMER_EN enables lane auto-unlock
module parking_lane_controller
    import parking_defs::*;
#(
    parameter int               N_LANES        = 2,
    parameter int               PIN_W          = 16,
    parameter logic [PIN_W-1:0] CORRECT_PIN    = 16'h2468,
    parameter int               MAX_ATTEMPTS   = 3,
    parameter int               CLOSE_CYCLES   = 4,
    parameter int               CAPACITY       = 8,
    parameter int               LOCKOUT_CYCLES = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_LANES-1:0]           vehicle_arrival,
    input  logic [N_LANES-1:0]           vehicle_left,
    input  logic [N_LANES*PIN_W-1:0]     code,
    input  logic [N_LANES-1:0]           code_ack,
    input  logic [N_LANES-1:0]           admin_unlock,
    input  logic                         vehicle_exit,
    output logic [N_LANES-1:0]           open_gate,
    output logic [N_LANES-1:0]           close_gate,
    output logic [N_LANES-1:0]           wrong_pin,
    output logic [N_LANES-1:0]           blocked_gate,
    output logic [cnt_w(CAPACITY)-1:0]   occupancy,
    output logic                         lot_full,
    output logic                         overflow
);

    localparam int OW = cnt_w(CAPACITY);
    localparam int SW = OW + cnt_w(N_LANES) + 1;

    if (MAX_ATTEMPTS < 1 || CLOSE_CYCLES < 1 || CAPACITY < 1 || LOCKOUT_CYCLES < 1 || N_LANES < 1) begin : g_bad_param
        $error("parking_lane_controller: parameter out of range");
    end

    logic [N_LANES-1:0] w_inc;
    logic [SW-1:0]      w_sum;
    logic [SW-1:0]      w_net;
    logic               w_over;
    logic [OW-1:0]      r_occ;
    logic               r_ovf;

    for (genvar g = 0; g < N_LANES; g++) begin : g_lane
        parking_lane_fsm #(
            .PIN_W         (PIN_W),
            .CORRECT_PIN   (CORRECT_PIN),
            .MAX_ATTEMPTS  (MAX_ATTEMPTS),
            .CLOSE_CYCLES  (CLOSE_CYCLES),
            .LOCKOUT_CYCLES(LOCKOUT_CYCLES)
        ) u_lane (
            .clk           (clk),
            .rst           (rst),
            .i_arrival     (vehicle_arrival[g]),
            .i_left        (vehicle_left[g]),
            .i_code        (code[g*PIN_W +: PIN_W]),
            .i_code_ack    (code_ack[g]),
            .i_admin_unlock(admin_unlock[g]),
            .i_lot_full    (lot_full),
            .o_open        (open_gate[g]),
            .o_close       (close_gate[g]),
            .o_wrong       (wrong_pin[g]),
            .o_blocked     (blocked_gate[g]),
            .o_inc         (w_inc[g])
        );
    end

    // unsaturated next occupancy: entries added first so a same-cycle exit nets out, floored at zero
    always_comb begin
        w_sum = SW'(r_occ);
        for (int i = 0; i < N_LANES; i++) w_sum = w_sum + SW'(w_inc[i]);
        w_net  = (vehicle_exit && w_sum != '0) ? w_sum - SW'(1) : w_sum;
        w_over = w_net > SW'(CAPACITY);
    end

    // occupancy saturates at capacity; overflow remembers any clipped entry
    always_ff @(posedge clk) begin
        if (rst) begin
            r_occ <= '0;
            r_ovf <= 1'b0;
        end else begin
            r_occ <= w_over ? OW'(CAPACITY) : w_net[OW-1:0];
            if (w_over) r_ovf <= 1'b1;
        end
    end

    assign occupancy = r_occ;
    assign lot_full  = r_occ == OW'(CAPACITY);
    assign overflow  = r_ovf;

endmodule

// File: tb/tb_parking_lane_controller.sv
// tb_parking_lane_controller: directed scenarios plus random traffic checked every cycle against a behavioural lot model
module tb_parking_lane_controller;

    localparam int          N     = 2;
    localparam int          PW    = 16;
    localparam int          CAP   = 8;
    localparam int          CLOSE = 4;
    localparam int          MAXA  = 3;
    localparam int          LOCK  = 64;
    localparam logic [15:0] PIN   = 16'h2468;
    localparam logic [15:0] BAD   = 16'h1111;
`ifdef LOCKOUT_TIMER_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    localparam int M_IDLE = 0, M_WAIT = 1, M_WRONG = 2, M_OPEN = 3, M_CLOSE = 4, M_BLK = 5;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    arr = '0, lft = '0, ack = '0, unl = '0;
    logic [N*PW-1:0] code = '0;
    logic            ex = 1'b0;
    logic [N-1:0]    og, cg, wp, bg;
    logic [3:0]      occ;
    logic            full, ovf;

    int n_chk = 0;
    int n_fail = 0;

    int m_ph[N], m_att[N], m_rem[N], m_lock[N];
    int m_occ = 0;
    bit m_ovf = 1'b0;

    parking_lane_controller dut (
        .clk(clk), .rst(rst),
        .vehicle_arrival(arr), .vehicle_left(lft), .code(code), .code_ack(ack),
        .admin_unlock(unl), .vehicle_exit(ex),
        .open_gate(og), .close_gate(cg), .wrong_pin(wp), .blocked_gate(bg),
        .occupancy(occ), .lot_full(full), .overflow(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // behavioural model: advance on every edge from the sampled inputs, then compare just after the edge
    initial begin
        for (int i = 0; i < N; i++) begin
            m_ph[i] = M_IDLE; m_att[i] = 0; m_rem[i] = 0; m_lock[i] = 0;
        end
        forever begin
            @(posedge clk);
            if (rst) begin
                for (int i = 0; i < N; i++) begin
                    m_ph[i] = M_IDLE; m_att[i] = 0;
                end
                m_occ = 0; m_ovf = 1'b0;
            end else begin
                bit was_full;
                int incs, s;
                was_full = (m_occ == CAP);
                incs = 0;
                for (int i = 0; i < N; i++) begin
                    case (m_ph[i])
                        M_IDLE:  if (arr[i] && !was_full) m_ph[i] = M_WAIT;
                        M_WAIT:  if (ack[i]) begin
                                     if (code[i*PW +: PW] == PIN) begin
                                         m_ph[i] = M_OPEN; m_att[i] = 0;
                                     end else begin
                                         m_att[i]++;
                                         m_ph[i] = (m_att[i] == MAXA) ? M_BLK : M_WRONG;
                                         m_lock[i] = 0;
                                     end
                                 end else if (lft[i]) m_ph[i] = M_IDLE;
                        M_WRONG: if (!ack[i]) m_ph[i] = M_WAIT;
                        M_OPEN:  if (lft[i]) begin
                                     if (arr[i]) begin
                                         m_ph[i] = M_BLK; m_lock[i] = 0;
                                     end else begin
                                         m_ph[i] = M_CLOSE; m_rem[i] = CLOSE; incs++;
                                     end
                                 end
                        M_CLOSE: begin
                                     m_rem[i]--;
                                     if (m_rem[i] == 0) m_ph[i] = M_IDLE;
                                 end
                        default: begin
                                     m_lock[i]++;
                                     if (unl[i] || (LOCK_EN && m_lock[i] == LOCK)) begin
                                         m_ph[i] = M_IDLE; m_att[i] = 0;
                                     end
                                 end
                    endcase
                end
                s = m_occ + incs - int'(ex);
                if (s > CAP) begin
                    m_occ = CAP; m_ovf = 1'b1;
                end else m_occ = (s < 0) ? 0 : s;
            end
            #1;
            for (int i = 0; i < N; i++) begin
                chk($sformatf("model open_gate[%0d]", i),    32'(og[i]), 32'(m_ph[i] == M_OPEN));
                chk($sformatf("model close_gate[%0d]", i),   32'(cg[i]), 32'(m_ph[i] == M_CLOSE));
                chk($sformatf("model wrong_pin[%0d]", i),    32'(wp[i]), 32'(m_ph[i] == M_WRONG));
                chk($sformatf("model blocked_gate[%0d]", i), 32'(bg[i]), 32'(m_ph[i] == M_BLK));
            end
            chk("model occupancy", 32'(occ),  32'(m_occ));
            chk("model lot_full",  32'(full), 32'(m_occ == CAP));
            chk("model overflow",  32'(ovf),  32'(m_ovf));
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_code(input int l, input logic [15:0] v);
        code[l*PW +: PW] = v;
    endtask

    task automatic enter(input int l);
        arr[l] = 1'b1; cyc(); arr[l] = 1'b0;
        set_code(l, PIN); ack[l] = 1'b1; cyc(); ack[l] = 1'b0;
        lft[l] = 1'b1; cyc(); lft[l] = 1'b0;
        cyc(CLOSE);
    endtask

    task automatic block_lane(input int l);
        arr[l] = 1'b1; cyc(); arr[l] = 1'b0;
        set_code(l, BAD);
        repeat (MAXA) begin
            ack[l] = 1'b1; cyc(); ack[l] = 1'b0; cyc();
        end
    endtask

    initial begin
        cyc(2); rst = 1'b0; cyc();
        chk("reset occupancy", 32'(occ), 0);
        chk("reset gates", {og, cg, wp, bg}, 0);
        chk("reset flags", {full, ovf}, 0);

        arr[0] = 1'b1; cyc(); arr[0] = 1'b0;
        set_code(0, PIN); ack[0] = 1'b1; cyc(); ack[0] = 1'b0;
        chk("correct pin opens", 32'(og), 32'h1);
        lft[0] = 1'b1; cyc(); lft[0] = 1'b0;
        chk("close after left", 32'(cg), 32'h1);
        chk("entry counted", 32'(occ), 1);
        cyc(3);
        chk("close fourth cycle", 32'(cg), 32'h1);
        cyc();
        chk("close ends", 32'(cg), 0);

        arr[1] = 1'b1; cyc(); arr[1] = 1'b0;
        set_code(1, BAD);
        ack[1] = 1'b1; cyc(); chk("wrong pin 1", 32'(wp), 32'h2);
        ack[1] = 1'b0; cyc(); chk("wrong pin drops", 32'(wp), 0);
        ack[1] = 1'b1; cyc(); chk("wrong pin 2", 32'(wp), 32'h2);
        ack[1] = 1'b0; cyc();
        ack[1] = 1'b1; cyc(); chk("third wrong blocks", {wp, bg}, 32'h2);
        ack[1] = 1'b0;
        unl[1] = 1'b1; cyc(); unl[1] = 1'b0;
        chk("unlock clears block", 32'(bg), 0);
        arr[1] = 1'b1; cyc(); arr[1] = 1'b0;
        ack[1] = 1'b1; cyc(); ack[1] = 1'b0;
        chk("attempts cleared by unlock", {wp, bg}, 32'h8);
        cyc(); lft[1] = 1'b1; cyc(); lft[1] = 1'b0;

        arr[0] = 1'b1; cyc(); arr[0] = 1'b0;
        set_code(0, PIN); ack[0] = 1'b1; cyc(); ack[0] = 1'b0;
        lft[0] = 1'b1; arr[0] = 1'b1; cyc(); lft[0] = 1'b0; arr[0] = 1'b0;
        chk("tailgate blocks", 32'(bg), 32'h1);
        chk("tailgate not counted", 32'(occ), 1);
        unl[0] = 1'b1; cyc(); unl[0] = 1'b0;

        repeat (6) enter(0);
        chk("filled to seven", 32'(occ), 7);
        arr = 2'b11; cyc(); arr = '0;
        set_code(0, PIN); set_code(1, PIN); ack = 2'b11; cyc(); ack = '0;
        chk("both lanes open", 32'(og), 32'h3);
        lft[0] = 1'b1; cyc(); lft[0] = 1'b0;
        chk("lot full at eight", {28'(occ), 3'b0, full}, {28'd8, 4'b0001});
        lft[1] = 1'b1; ex = 1'b1; cyc(); lft[1] = 1'b0; ex = 1'b0;
        chk("entry with exit nets out", {28'(occ), 3'b0, ovf}, {28'd8, 4'b0000});
        cyc(CLOSE);
        arr[0] = 1'b1; cyc(); arr[0] = 1'b0;
        ack[0] = 1'b1; cyc(); ack[0] = 1'b0;
        chk("arrival ignored when full", 32'(og), 0);
        ex = 1'b1; cyc(); ex = 1'b0;
        chk("exit leaves seven", {28'(occ), 3'b0, full}, {28'd7, 4'b0000});
        arr = 2'b11; cyc(); arr = '0;
        ack = 2'b11; cyc(); ack = '0;
        lft = 2'b11; cyc(); lft = '0;
        chk("double entry saturates", {28'(occ), 3'b0, ovf}, {28'd8, 4'b0001});
        cyc(CLOSE);
        ex = 1'b1; cyc(9); ex = 1'b0;
        chk("exit at empty stays zero", 32'(occ), 0);
        chk("overflow sticky", 32'(ovf), 1);

        arr[0] = 1'b1; cyc(); arr[0] = 1'b0;
        ack[0] = 1'b1; cyc(); ack[0] = 1'b0;
        lft[0] = 1'b1; cyc(); lft[0] = 1'b0;
        cyc();
        rst = 1'b1; cyc(); rst = 1'b0;
        chk("reset during closing", {og, cg, wp, bg, 28'(occ), 2'b0, full, ovf}, 0);
        block_lane(1);
        chk("blocked again", 32'(bg), 32'h2);
        rst = 1'b1; cyc(); rst = 1'b0;
        chk("reset during blocked", 32'(bg), 0);
`ifdef LOCKOUT_TIMER_EN
        arr[1] = 1'b1; cyc(); arr[1] = 1'b0;
        set_code(1, BAD);
        ack[1] = 1'b1; cyc(); ack[1] = 1'b0; cyc();
        ack[1] = 1'b1; cyc(); ack[1] = 1'b0; cyc();
        ack[1] = 1'b1; cyc(); ack[1] = 1'b0;
        cyc(LOCK - 1);
        chk("lockout still held", 32'(bg), 32'h2);
        cyc();
        chk("lockout released", 32'(bg), 0);
`endif

        for (int c = 0; c < 4000; c++) begin
            int pe;
            pe = (c % 800 < 400) ? 3 : 25;
            for (int i = 0; i < N; i++) begin
                arr[i] = $urandom_range(99, 0) < 30;
                lft[i] = $urandom_range(99, 0) < 20;
                ack[i] = $urandom_range(99, 0) < 40;
                unl[i] = $urandom_range(99, 0) < 8;
                set_code(i, ($urandom_range(99, 0) < 55) ? PIN : 16'($urandom));
            end
            ex  = $urandom_range(99, 0) < pe;
            rst = $urandom_range(999, 0) < 5;
            cyc();
        end
        rst = 1'b0; arr = '0; lft = '0; ack = '0; unl = '0; ex = 1'b0;
        cyc(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/parking_lane_controller.md
# parking_lane_controller

Multi-lane parking access controller: N_LANES independent gate FSMs, each with PIN entry, bounded retries, timed gate closing, tailgate detection and admin unlock. A shared occupancy counter refuses new arrivals when the lot is full. It sits between the lane sensors/keypads and the gate actuators and replaces the single-lane controller in the top-level lot design.

## Interface
- N_LANES, 2, number of independent entry lanes
- PIN_W, 16, PIN width in bits
- CORRECT_PIN, 16'h2468, accepted PIN, common to all lanes, PIN_W bits
- MAX_ATTEMPTS, 3, wrong PINs allowed before a lane blocks (≥1)
- CLOSE_CYCLES, 4, cycles close_gate stays asserted (≥1)
- CAPACITY, 8, lot capacity in vehicles (≥1)
- LOCKOUT_CYCLES, 64, auto-unlock delay; used only with LOCKOUT_TIMER_EN
- clk  in  1  clock; all logic on posedge
- rst  in  1  reset: synchronous, active-high
- vehicle_arrival  in  N_LANES  per-lane arrival sensor, level
- vehicle_left  in  N_LANES  per-lane vehicle-passed/departed sensor, level
- code  in  N_LANES*PIN_W  per-lane PIN; lane i at [i*PIN_W +: PIN_W]
- code_ack  in  N_LANES  per-lane PIN valid strobe, level
- admin_unlock  in  N_LANES  per-lane unlock of a BLOCKED lane
- vehicle_exit  in  1  one-cycle pulse: one vehicle left the lot
- open_gate  out  N_LANES  gate open command
- close_gate  out  N_LANES  gate close command
- wrong_pin  out  N_LANES  wrong-PIN indication
- blocked_gate  out  N_LANES  lane blocked alarm
- occupancy  out  $clog2(CAPACITY+1)  vehicles inside
- lot_full  out  1  occupancy == CAPACITY
- overflow  out  1  sticky: an entry was counted while full

## Operation
- Per-lane states: IDLE, WAIT_PIN, WRONG_PIN, OPEN, CLOSING, BLOCKED. Moore outputs decoded from the state register.
- IDLE: vehicle_arrival && !lot_full → WAIT_PIN. Arrival while full is ignored, and the lane stays IDLE.
- WAIT_PIN: code_ack → OPEN if code == CORRECT_PIN. Otherwise attempts+1: → BLOCKED if the new count == MAX_ATTEMPTS, else → WRONG_PIN. vehicle_left without code_ack → IDLE. code_ack has priority over vehicle_left. vehicle_left does not clear attempts.
- WRONG_PIN: wrong_pin=1. Returns to WAIT_PIN on the first cycle code_ack is sampled low.
- OPEN: open_gate=1, attempts cleared. vehicle_left && vehicle_arrival → BLOCKED (tailgate). vehicle_left alone → CLOSING, and the lane issues an entry increment.
- CLOSING: close_gate=1 for exactly CLOSE_CYCLES cycles, then → IDLE.
- BLOCKED: blocked_gate=1. admin_unlock → IDLE and clears attempts.
- Attempt counter width: $clog2(MAX_ATTEMPTS+1).
- Occupancy update per cycle: new = occupancy + (count of lane increments) − vehicle_exit.
  - Saturates at CAPACITY; overflow sets if the unsaturated result exceeds CAPACITY.
  - Saturates at 0 when exiting an empty lot.
  - Simultaneous entry and exit net out.

## Timing
- Reset: every lane is IDLE with attempts=0. occupancy=0; open_gate, close_gate, wrong_pin, blocked_gate, lot_full and overflow are all 0. Reset mid-operation aborts any state, including BLOCKED and CLOSING.
- Input sampled at edge t → new state and outputs visible after edge t (1-cycle latency). No combinational input→output paths.
- A correct PIN with code_ack at t gives open_gate=1 from t+1.
- CLOSING entered at t gives close_gate high for cycles t+1 .. t+CLOSE_CYCLES, then IDLE.
- An occupancy increment lands on the same edge the lane enters CLOSING. lot_full follows occupancy in the same cycle.
- The full check uses registered occupancy. An arrival accepted one cycle before full still proceeds, and any resulting overflow is flagged.

## Configuration
- LOCKOUT_TIMER_EN defined: BLOCKED auto-returns to IDLE after LOCKOUT_CYCLES cycles and clears attempts; admin_unlock still exits early. Per-lane timer width is $clog2(LOCKOUT_CYCLES+1).
- LOCKOUT_TIMER_EN undefined: BLOCKED exits only on admin_unlock or rst, and no timer logic is built.

## Structure
- Shared package/header parking_defs: state encodings (IDLE..BLOCKED, 3 bits) and shared width helper constants.
- Sub-module parking_lane_fsm: one lane containing the FSM, attempt counter, close counter and optional lockout timer. The top level instantiates N_LANES copies in a generate loop and holds the occupancy counter.

## Test plan
- Lane 0: arrival, code=16'h2468 with ack → open_gate[0]=1 next cycle. Then vehicle_left → close_gate[0]=1 for 4 cycles, then IDLE, occupancy=1.
- Lane 1: three wrong PINs (16'h1111), each followed by ack low → wrong_pin pulses twice, then blocked_gate[1]=1. admin_unlock → IDLE and attempts=0.
- OPEN with vehicle_left and vehicle_arrival in the same cycle → blocked_gate=1, occupancy unchanged.
- Fill to 8 entries → lot_full=1 and the next arrival stays IDLE. vehicle_exit together with a lane entry → occupancy stays 8.
- Occupancy 7, both lanes enter in the same cycle → occupancy=8 and overflow=1. vehicle_exit at 0 → occupancy stays 0.
- rst asserted during CLOSING and during BLOCKED → all outputs 0 next cycle. With LOCKOUT_TIMER_EN, BLOCKED clears after 64 cycles.
